// File: rtl/register_read_stage_pkg.sv
// Shared widths and the ID/EX bundle for the register-read stage.
// Also provides the immediate sign-extension helper.
package register_read_stage_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int REGISTER_NUMBER_LOG = 5;
  localparam int IMM_WIDTH           = 16;
  localparam int OP_WIDTH            = 6;

  typedef logic [DATA_WIDTH-1:0]          data_t;
  typedef logic [REGISTER_NUMBER_LOG-1:0] reg_idx_t;
  typedef logic [IMM_WIDTH-1:0]           imm_t;
  typedef logic [OP_WIDTH-1:0]            op_t;

  typedef struct packed {
    op_t      op;
    reg_idx_t rd;
    data_t    opA;
    data_t    opB;
    data_t    imm;
    logic     isLoad;
    logic     writesReg;
  } id_ex_t;

  function automatic data_t sign_extend(imm_t v);
    return {{(DATA_WIDTH-IMM_WIDTH){v[IMM_WIDTH-1]}}, v};
  endfunction

endpackage

// File: rtl/register_read_stage_if.sv
// Decode-side and ID/EX-side handshakes of the register-read stage.
// master is the stage's view, slave the surrounding pipeline's view.
interface register_read_stage_if;
  import register_read_stage_pkg::*;

  logic     inValid;
  logic     inReady;
  op_t      inOp;
  reg_idx_t inRs;
  reg_idx_t inRt;
  reg_idx_t inRd;
  imm_t     inImm;
  logic     inIsLoad;
  logic     inWritesReg;

  logic     outValid;
  logic     outReady;
  op_t      outOp;
  reg_idx_t outRd;
  data_t    outOpA;
  data_t    outOpB;
  data_t    outImm;
  logic     outIsLoad;
  logic     outWritesReg;

  modport master (
    input  inValid, inOp, inRs, inRt, inRd,
    input  inImm, inIsLoad, inWritesReg,
    output inReady,
    output outValid, outOp, outRd, outOpA,
    output outOpB, outImm, outIsLoad, outWritesReg,
    input  outReady
  );

  modport slave (
    output inValid, inOp, inRs, inRt, inRd,
    output inImm, inIsLoad, inWritesReg,
    input  inReady,
    input  outValid, outOp, outRd, outOpA,
    input  outOpB, outImm, outIsLoad, outWritesReg,
    output outReady
  );

endinterface

// File: rtl/register_read_stage_operand_bypass_mux.sv
// Resolves one source operand from EX/MEM/WB bypasses or the regfile.
// Also flags a pending load in EX that this source depends on.
module operand_bypass_mux
  import register_read_stage_pkg::*;
(
  input  reg_idx_t index,
  input  data_t    readValue,
  input  logic     exValid,
  input  logic     exIsLoad,
  input  reg_idx_t exIndex,
  input  data_t    exValue,
  input  logic     memValid,
  input  reg_idx_t memIndex,
  input  data_t    memValue,
  input  reg_idx_t wbIndex,
  input  data_t    wbValue,
  output data_t    operand,
  output logic     loadHit
);

  logic zero_idx;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign zero_idx = (index == '0);
  assign ex_hit   = exValid && !exIsLoad && (exIndex == index);
  assign mem_hit  = memValid && (memIndex == index);
  assign wb_hit   = (wbIndex != '0) && (wbIndex == index);
  assign loadHit  = exValid && exIsLoad && (exIndex != '0)
                    && (exIndex == index);

  // Youngest producer wins; register 0 is hardwired to zero.
  always_comb begin
    operand = readValue;
    priority case (1'b1)
      zero_idx: operand = '0;
      ex_hit:   operand = exValue;
      mem_hit:  operand = memValue;
      wb_hit:   operand = wbValue;
      default:  operand = readValue;
    endcase
  end

endmodule

// File: rtl/register_read_stage.sv
// Register-read stage: bypassing, load-use stall and ID/EX register.
// Optional STALL_COUNTER_EN adds the perfStallCycles counter output.
module register_read_stage
  import register_read_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  register_read_stage_if.master bus,
  output reg_idx_t readIndexA,
  output reg_idx_t readIndexB,
  input  data_t    readValueA,
  input  data_t    readValueB,
  input  logic     exValid,
  input  logic     exIsLoad,
  input  reg_idx_t exIndex,
  input  data_t    exValue,
  input  logic     memValid,
  input  reg_idx_t memIndex,
  input  data_t    memValue,
  input  reg_idx_t wbIndex,
  input  data_t    wbValue,
  input  logic     flush
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0] perfStallCycles
`endif
);

  data_t  opA;
  data_t  opB;
  logic   hitA;
  logic   hitB;
  logic   stall;
  logic   ready;
  logic   capture;
  logic   valid_q;
  id_ex_t nxt;
  id_ex_t q;

  assign readIndexA = bus.inRs;
  assign readIndexB = bus.inRt;

  operand_bypass_mux u_mux_a (
    .index    (bus.inRs),
    .readValue(readValueA),
    .exValid  (exValid),
    .exIsLoad (exIsLoad),
    .exIndex  (exIndex),
    .exValue  (exValue),
    .memValid (memValid),
    .memIndex (memIndex),
    .memValue (memValue),
    .wbIndex  (wbIndex),
    .wbValue  (wbValue),
    .operand  (opA),
    .loadHit  (hitA)
  );

  operand_bypass_mux u_mux_b (
    .index    (bus.inRt),
    .readValue(readValueB),
    .exValid  (exValid),
    .exIsLoad (exIsLoad),
    .exIndex  (exIndex),
    .exValue  (exValue),
    .memValid (memValid),
    .memIndex (memIndex),
    .memValue (memValue),
    .wbIndex  (wbIndex),
    .wbValue  (wbValue),
    .operand  (opB),
    .loadHit  (hitB)
  );

  assign stall   = bus.inValid && (hitA || hitB);
  assign ready   = !stall && !flush && (!valid_q || bus.outReady);
  assign capture = bus.inValid && ready;

  assign bus.inReady = ready;

  // Assemble the bundle that would be latched this cycle.
  always_comb begin
    nxt           = '0;
    nxt.op        = bus.inOp;
    nxt.rd        = bus.inRd;
    nxt.opA       = opA;
    nxt.opB       = opB;
    nxt.imm       = sign_extend(bus.inImm);
    nxt.isLoad    = bus.inIsLoad;
    nxt.writesReg = bus.inWritesReg;
  end

  // ID/EX register: flush squashes, capture loads, drain clears valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q <= 1'b1;
      q       <= nxt;
    end else if (bus.outReady) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.outValid     = valid_q;
  assign bus.outOp        = q.op;
  assign bus.outRd        = q.rd;
  assign bus.outOpA       = q.opA;
  assign bus.outOpB       = q.opB;
  assign bus.outImm       = q.imm;
  assign bus.outIsLoad    = q.isLoad;
  assign bus.outWritesReg = q.writesReg;

`ifdef STALL_COUNTER_EN
  // Count cycles a presented instruction is held back (not flushes).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perfStallCycles <= '0;
    else if (bus.inValid && !ready && !flush)
      perfStallCycles <= perfStallCycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_register_read_stage.sv
// Self-checking bench for register_read_stage.
// Directed scenarios plus randomized traffic against a reference model.
module tb_register_read_stage;
  import register_read_stage_pkg::*;

  logic     clk = 1'b0;
  logic     reset;
  reg_idx_t readIndexA, readIndexB;
  data_t    readValueA, readValueB;
  logic     exValid, exIsLoad;
  reg_idx_t exIndex;
  data_t    exValue;
  logic     memValid;
  reg_idx_t memIndex;
  data_t    memValue;
  reg_idx_t wbIndex;
  data_t    wbValue;
  logic     flush;
`ifdef STALL_COUNTER_EN
  logic [31:0] perfStallCycles;
`endif

  int checks = 0;
  int errors = 0;

  register_read_stage_if bus();

  register_read_stage dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .readIndexA(readIndexA),
    .readIndexB(readIndexB),
    .readValueA(readValueA),
    .readValueB(readValueB),
    .exValid   (exValid),
    .exIsLoad  (exIsLoad),
    .exIndex   (exIndex),
    .exValue   (exValue),
    .memValid  (memValid),
    .memIndex  (memIndex),
    .memValue  (memValue),
    .wbIndex   (wbIndex),
    .wbValue   (wbValue),
    .flush     (flush)
`ifdef STALL_COUNTER_EN
    ,
    .perfStallCycles(perfStallCycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.inValid = 0; bus.inOp = 0; bus.inRs = 0; bus.inRt = 0;
    bus.inRd = 0; bus.inImm = 0; bus.inIsLoad = 0;
    bus.inWritesReg = 0; bus.outReady = 1;
    readValueA = 0; readValueB = 0;
    exValid = 0; exIsLoad = 0; exIndex = 0; exValue = 0;
    memValid = 0; memIndex = 0; memValue = 0;
    wbIndex = 0; wbValue = 0; flush = 0;
  endtask

  task automatic test_reset;
    checks++;
    if (bus.outValid !== 1'b0 || bus.outOpA !== '0) begin
      errors++;
      $display("FAIL reset_initial: outValid=%0b outOpA=%h want 0",
               bus.outValid, bus.outOpA);
    end
    reset = 1;
    bus.inValid = 1; bus.inRs = 3; readValueA = 7;
    bus.inOp = 5; bus.inRd = 9; bus.inImm = 16'h0010;
    step();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outOpA !== 32'd7) begin
      errors++;
      $display("FAIL reset_precapture: outValid=%0b outOpA=%h want 1/7",
               bus.outValid, bus.outOpA);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.outValid !== 0 || bus.outOpA !== 0 || bus.outOp !== 0 ||
        bus.outRd !== 0 || bus.outImm !== 0 || bus.outOpB !== 0) begin
      errors++;
      $display("FAIL reset_async: v=%0b a=%h op=%h rd=%h imm=%h want 0",
               bus.outValid, bus.outOpA, bus.outOp, bus.outRd,
               bus.outImm);
    end
    step();
    checks++;
    if (bus.outValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: outValid=%0b want 0", bus.outValid);
    end
    reset = 1;
    step();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outOpA !== 32'd7 ||
        bus.outRd !== 5'd9 || bus.outImm !== 32'h10) begin
      errors++;
      $display("FAIL reset_release: v=%0b a=%h rd=%h want 1/7/9",
               bus.outValid, bus.outOpA, bus.outRd);
    end
  endtask

  task automatic test_priority;
    bus.inValid = 1; bus.outReady = 1; bus.inRs = 5;
    exValid = 1; exIsLoad = 0; exIndex = 5; exValue = 11;
    memValid = 1; memIndex = 5; memValue = 22;
    wbIndex = 5; wbValue = 33; readValueA = 44;
    step();
    checks++;
    if (bus.outOpA !== 32'd11) begin
      errors++;
      $display("FAIL prio_ex: outOpA=%0d want 11", bus.outOpA);
    end
    exValid = 0;
    step();
    checks++;
    if (bus.outOpA !== 32'd22) begin
      errors++;
      $display("FAIL prio_mem: outOpA=%0d want 22", bus.outOpA);
    end
    memValid = 0;
    step();
    checks++;
    if (bus.outOpA !== 32'd33) begin
      errors++;
      $display("FAIL prio_wb: outOpA=%0d want 33", bus.outOpA);
    end
    wbIndex = 0;
    step();
    checks++;
    if (bus.outOpA !== 32'd44) begin
      errors++;
      $display("FAIL prio_rf: outOpA=%0d want 44", bus.outOpA);
    end
    exValid = 1; memValid = 1; wbIndex = 5;
    exIndex = 0; memIndex = 0; bus.inRs = 0;
    step();
    checks++;
    if (bus.outOpA !== 32'd0) begin
      errors++;
      $display("FAIL prio_zero: outOpA=%0d want 0", bus.outOpA);
    end
    clear_inputs();
  endtask

  task automatic test_load_use;
    bus.inValid = 0;
    step();
    bus.inValid = 1; bus.inRs = 1; bus.inRt = 4;
    readValueA = 3; readValueB = 5;
    exValid = 1; exIsLoad = 1; exIndex = 4; exValue = 77;
    memValid = 1; memIndex = 4; memValue = 66;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.inReady !== 1'b0) begin
        errors++;
        $display("FAIL load_use_ready[%0d]: inReady=%0b want 0",
                 i, bus.inReady);
      end
      step();
      checks++;
      if (bus.outValid !== 1'b0) begin
        errors++;
        $display("FAIL load_use_bubble[%0d]: outValid=%0b want 0",
                 i, bus.outValid);
      end
    end
    exValid = 0; memValue = 99;
    #1;
    checks++;
    if (bus.inReady !== 1'b1) begin
      errors++;
      $display("FAIL load_use_release: inReady=%0b want 1", bus.inReady);
    end
    step();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outOpB !== 32'd99) begin
      errors++;
      $display("FAIL load_use_fwd: v=%0b opB=%0d want 1/99",
               bus.outValid, bus.outOpB);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    bus.inValid = 1; bus.outReady = 1;
    bus.inRs = 1; readValueA = 32'h111;
    bus.inRt = 2; readValueB = 32'h222; bus.inImm = 16'h1234;
    step();
    bus.outReady = 0;
    readValueA = 32'haaa; readValueB = 32'hbbb; bus.inImm = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.inReady !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: inReady=%0b want 0", i, bus.inReady);
      end
      step();
      checks++;
      if (bus.outValid !== 1 || bus.outOpA !== 32'h111 ||
          bus.outOpB !== 32'h222 || bus.outImm !== 32'h1234) begin
        errors++;
        $display("FAIL bp_hold[%0d]: v=%0b a=%h b=%h imm=%h",
                 i, bus.outValid, bus.outOpA, bus.outOpB, bus.outImm);
      end
    end
    bus.outReady = 1;
    step();
    checks++;
    if (bus.outValid !== 1 || bus.outOpA !== 32'haaa ||
        bus.outImm !== 32'h4321) begin
      errors++;
      $display("FAIL bp_release: v=%0b a=%h imm=%h want 1/aaa/4321",
               bus.outValid, bus.outOpA, bus.outImm);
    end
  endtask

  task automatic test_flush;
    bus.inValid = 1; flush = 1; bus.inImm = 16'h8001;
    #1;
    checks++;
    if (bus.inReady !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: inReady=%0b want 0", bus.inReady);
    end
    step();
    checks++;
    if (bus.outValid !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: outValid=%0b want 0", bus.outValid);
    end
    flush = 0;
    step();
    checks++;
    if (bus.outValid !== 1'b1 || bus.outImm !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL flush_imm: v=%0b imm=%h want 1/ffff8001",
               bus.outValid, bus.outImm);
    end
    clear_inputs();
  endtask

  function automatic data_t ref_operand(reg_idx_t idx, data_t rf);
    if (idx == 0) return '0;
    if (exValid && !exIsLoad && exIndex == idx) return exValue;
    if (memValid && memIndex == idx) return memValue;
    if (wbIndex != 0 && wbIndex == idx) return wbValue;
    return rf;
  endfunction

  task automatic test_random;
    logic   m_valid;
    id_ex_t m_reg;
    id_ex_t act;
    logic   load_dep;
    logic   exp_ready;
    clear_inputs();
    reset = 0;
    #2;
    reset = 1;
    m_valid = 0;
    m_reg = '0;
    step();
    for (int n = 0; n < 400; n++) begin
      bus.inValid = ($urandom_range(0, 3) != 0);
      bus.inOp = op_t'($urandom); bus.inRd = reg_idx_t'($urandom);
      bus.inRs = reg_idx_t'($urandom_range(0, 7));
      bus.inRt = reg_idx_t'($urandom_range(0, 7));
      bus.inImm = imm_t'($urandom);
      bus.inIsLoad = 1'($urandom); bus.inWritesReg = 1'($urandom);
      bus.outReady = ($urandom_range(0, 3) != 0);
      readValueA = $urandom; readValueB = $urandom;
      exValid = 1'($urandom); exIsLoad = ($urandom_range(0, 3) == 0);
      exIndex = reg_idx_t'($urandom_range(0, 7)); exValue = $urandom;
      memValid = 1'($urandom);
      memIndex = reg_idx_t'($urandom_range(0, 7)); memValue = $urandom;
      wbIndex = reg_idx_t'($urandom_range(0, 7)); wbValue = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      #1;
      load_dep = exValid && exIsLoad && exIndex != 0 &&
                 (exIndex == bus.inRs || exIndex == bus.inRt);
      exp_ready = !(bus.inValid && load_dep) && !flush &&
                  (!m_valid || bus.outReady);
      checks++;
      if (bus.inReady !== exp_ready || readIndexA !== bus.inRs ||
          readIndexB !== bus.inRt) begin
        errors++;
        $display("FAIL rand_ready[%0d]: inReady=%0b want %0b idx=%0d/%0d",
                 n, bus.inReady, exp_ready, readIndexA, readIndexB);
      end
      if (flush) begin
        m_valid = 0;
      end else if (bus.inValid && exp_ready) begin
        m_valid = 1;
        m_reg.op = bus.inOp;
        m_reg.rd = bus.inRd;
        m_reg.opA = ref_operand(bus.inRs, readValueA);
        m_reg.opB = ref_operand(bus.inRt, readValueB);
        m_reg.imm = 32'(signed'(bus.inImm));
        m_reg.isLoad = bus.inIsLoad;
        m_reg.writesReg = bus.inWritesReg;
      end else if (bus.outReady) begin
        m_valid = 0;
      end
      step();
      act.op = bus.outOp; act.rd = bus.outRd;
      act.opA = bus.outOpA; act.opB = bus.outOpB;
      act.imm = bus.outImm; act.isLoad = bus.outIsLoad;
      act.writesReg = bus.outWritesReg;
      checks++;
      if (bus.outValid !== m_valid || act !== m_reg) begin
        errors++;
        $display("FAIL rand_out[%0d]: v=%0b a=%h b=%h imm=%h want %0b %h %h %h",
                 n, bus.outValid, act.opA, act.opB, act.imm,
                 m_valid, m_reg.opA, m_reg.opB, m_reg.imm);
      end
    end
    clear_inputs();
  endtask

`ifdef STALL_COUNTER_EN
  task automatic test_stall_counter;
    clear_inputs();
    reset = 0;
    #2;
    reset = 1;
    checks++;
    if (perfStallCycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: perfStallCycles=%0d want 0",
               perfStallCycles);
    end
    bus.inValid = 1; bus.inRt = 6;
    exValid = 1; exIsLoad = 1; exIndex = 6;
    for (int i = 0; i < 5; i++) step();
    bus.inValid = 0; exValid = 0;
    checks++;
    if (perfStallCycles !== 32'd5) begin
      errors++;
      $display("FAIL perf_count: perfStallCycles=%0d want 5",
               perfStallCycles);
    end
    step();
    clear_inputs();
  endtask
`endif

  initial begin
    reset = 0;
    clear_inputs();
    #2;
    test_reset();
    clear_inputs();
    test_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
`ifdef STALL_COUNTER_EN
    test_stall_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_read_stage.md
Name: register_read_stage

Overview:
Decode/register-read pipeline stage that sits directly upstream of the RegisterFile.
- Drives the RegisterFile read indices from the incoming decoded instruction.
- Resolves operands with EX/MEM/WB bypassing and detects load-use hazards.
- Captures the resolved operands into a one-entry ID/EX pipeline register with a valid/ready handshake toward the execute stage.

Parameters:
DATA_WIDTH, 32, operand/register width
REGISTER_NUMBER_LOG, 5, register index width (32 registers; register 0 reads as zero)
IMM_WIDTH, 16, raw immediate width
OP_WIDTH, 6, opcode width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
inValid  in  1  decoded instruction present
inReady  out  1  stage accepts instruction this cycle
inOp  in  OP_WIDTH  opcode
inRs / inRt / inRd  in  REGISTER_NUMBER_LOG  source A, source B, destination indices
inImm  in  IMM_WIDTH  raw immediate
inIsLoad / inWritesReg  in  1  instruction class flags
readIndexA / readIndexB  out  REGISTER_NUMBER_LOG  to RegisterFile
readValueA / readValueB  in  DATA_WIDTH  from RegisterFile (combinational read)
exValid, exIsLoad  in  1  EX stage holds a reg-writing instruction / it is a load
exIndex  in  REGISTER_NUMBER_LOG; exValue  in  DATA_WIDTH  EX result
memValid  in  1; memIndex  in  REGISTER_NUMBER_LOG; memValue  in  DATA_WIDTH  MEM result
wbIndex  in  REGISTER_NUMBER_LOG; wbValue  in  DATA_WIDTH  RegisterFile write port (index 0 = no write)
flush  in  1  squash pipeline register (branch redirect)
outValid  out  1; outReady  in  1  ID/EX handshake
outOp, outRd, outIsLoad, outWritesReg  out  registered copies
outOpA / outOpB  out  DATA_WIDTH  resolved operands
outImm  out  DATA_WIDTH  sign-extended immediate

Behaviour:
- readIndexA = inRs and readIndexB = inRt, purely combinational.
- Operand resolution per source, first match wins:
  - index 0 -> 0
  - exValid && exIndex match && !exIsLoad -> exValue
  - memValid && memIndex match -> memValue
  - wbIndex != 0 && wbIndex match -> wbValue (same-cycle write bypass)
  - otherwise -> readValue
- stall = inValid && exValid && exIsLoad && exIndex != 0 && (exIndex == inRs || exIndex == inRt).
- inReady = !stall && !flush && (!outValid || outReady).
- Capture on inValid && inReady: all out* registered next edge, outValid <= 1. Latency is 1 cycle.
- If there is no capture and outValid && outReady, then outValid <= 0. A stall therefore inserts a bubble.
- While outValid && !outReady, all out* hold stable.
- flush: outValid <= 0 next edge, overrides capture. The input instruction is not consumed (inReady = 0).
- outImm = {{(DATA_WIDTH-IMM_WIDTH){inImm[IMM_WIDTH-1]}}, inImm}.
- reset low (asynchronous, any time, including mid-stall): outValid = 0; outOp, outRd, outOpA, outOpB, outImm, outIsLoad, outWritesReg = 0. On release, the first capture is possible at the next edge.
- Simultaneous exIndex == memIndex == wbIndex: EX wins. A load in EX with a match stalls even if MEM/WB also match.

Optional Feature:
STALL_COUNTER_EN
- Defined: adds output perfStallCycles (32 bits), cleared by reset.
  - Increments on every edge where inValid && !inReady && !flush.
  - Wraps at 2^32-1 -> 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package: DATA_WIDTH, REGISTER_NUMBER_LOG, IMM_WIDTH, OP_WIDTH constants; the ID/EX bundle typedef (op, rd, opA, opB, imm, isLoad, writesReg).
- Sub-module operand_bypass_mux, instantiated twice (A and B). It takes an index, readValue and the EX/MEM/WB bypass inputs, and returns the resolved operand and the load-hazard hit.

Test Plan:
- Reset low mid-capture, with inValid=1: outValid=0 and all outputs 0 immediately. After release, inRs=3 with readValueA=7 gives outOpA=7 and outValid=1 one cycle later.
- Priority: inRs=5 with exIndex=5 (exValue=11), memIndex=5 (22), wbIndex=5 (33), readValueA=44 gives outOpA=11. Drop exValid: 22. Drop memValid: 33. Set wbIndex=0: 44. With inRs=0 under any bypass: 0.
- Load-use: exValid=1, exIsLoad=1, exIndex=4, inRt=4 gives inReady=0 for exactly the cycles the load stays in EX, with outValid=0 after drain. The cycle exValid falls, the instruction is captured with outOpB=memValue.
- Backpressure: outReady=0 for 3 cycles after capture gives outValid=1 and outOpA/outOpB/outImm unchanged, with inReady=0. outReady=1 gives a new capture the same edge.
- flush while outValid=1 and inValid=1 gives outValid=0 next cycle and the input not consumed. inImm=0x8001 gives outImm=0xFFFF8001.
- STALL_COUNTER_EN defined: 5 load-use stall cycles gives perfStallCycles=5. Preloading to 0xFFFFFFFF then one stall gives 0.
